// File: rtl/matmul_mac_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_mac_sequencer
//
// Sequences a single shared MAC to compute C = A x B for square DIM x DIM
// matrices. For every element C[i][j] it clears the MAC, then streams
// A[i][k] / B[k][j] out of two registered-read buffers. Once the MAC pipeline
// has drained, the truncated result is written into the C buffer.
//
// Ports:
//   clock_i        system clock, rising edge
//   reset_ni       asynchronous active-low reset
//   start_i        begin a full multiply (sampled in IDLE only)
//   busy_o         high in every state except IDLE
//   done_o         one-cycle pulse after the last C element is written
//   a_rd_en_o      A buffer read strobe
//   a_addr_o       A address, row-major i*DIM+k
//   b_rd_en_o      B buffer read strobe
//   b_addr_o       B address, row-major k*DIM+j
//   mac_clear_n_o  MAC synchronous active-low clear
//   mac_enable_o   MAC enable
//   mac_result_i   MAC truncated accumulator
//   mac_overflow_i MAC overflow flag
//   c_wr_en_o      C buffer write strobe
//   c_addr_o       C address i*DIM+j
//   c_data_o       value written to C
//   c_overflow_o   MAC overflow for the element being written
//   ovf_sticky_o   OR of c_overflow over the current/last run
// -----------------------------------------------------------------------------
module matmul_mac_sequencer #(
    parameter int DIM        = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  a_rd_en_o,
    output logic [ADDR_WIDTH-1:0] a_addr_o,
    output logic                  b_rd_en_o,
    output logic [ADDR_WIDTH-1:0] b_addr_o,
    output logic                  mac_clear_n_o,
    output logic                  mac_enable_o,
    input  logic [DATA_WIDTH-1:0] mac_result_i,
    input  logic                  mac_overflow_i,
    output logic                  c_wr_en_o,
    output logic [ADDR_WIDTH-1:0] c_addr_o,
    output logic [DATA_WIDTH-1:0] c_data_o,
    output logic                  c_overflow_o,
    output logic                  ovf_sticky_o
);

    localparam int IW = $clog2(DIM);
    // k doubles as the ACCUM cycle number, which runs up to DIM+1.
    localparam int KW = $clog2(DIM + 2);

    localparam logic [IW-1:0]         IDX_LAST = IW'(DIM - 1);
    localparam logic [IW-1:0]         IDX_ONE  = IW'(1);
    localparam logic [KW-1:0]         K_ONE    = KW'(1);
    localparam logic [KW-1:0]         K_DIM    = KW'(DIM);
    localparam logic [KW-1:0]         K_LAST   = KW'(DIM + 1);
    localparam logic [ADDR_WIDTH-1:0] DIM_A    = ADDR_WIDTH'(DIM);
    localparam logic [ADDR_WIDTH-1:0] K_HOLD_A = ADDR_WIDTH'(DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_WRITE,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   j_q, j_d;
    logic [KW-1:0]   k_q, k_d;
    logic            sticky_q, sticky_d;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        sticky_d = sticky_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_CLEAR;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    sticky_d = 1'b0;
                end
            end
            S_CLEAR: begin
                k_d     = K_ONE;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                // Two extra cycles after the last read let the buffer
                // latency and the MAC's second stage drain.
                if (k_q == K_LAST) begin
                    state_d = S_WRITE;
                end else begin
                    k_d = k_q + K_ONE;
                end
            end
            S_WRITE: begin
                sticky_d = sticky_q | mac_overflow_i;
                k_d      = '0;
                if (j_q != IDX_LAST) begin
                    j_d     = j_q + IDX_ONE;
                    state_d = S_CLEAR;
                end else if (i_q != IDX_LAST) begin
                    j_d     = '0;
                    i_d     = i_q + IDX_ONE;
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic [ADDR_WIDTH-1:0] k_addr;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] col;

    always_comb begin
        // Once the reads stop, the operand addresses freeze at k = DIM-1.
        k_addr   = (k_q >= K_DIM) ? K_HOLD_A : ADDR_WIDTH'(k_q);
        row_base = ADDR_WIDTH'(i_q) * DIM_A;
        col      = ADDR_WIDTH'(j_q);

        busy_o        = (state_q != S_IDLE);
        done_o        = 1'b0;
        a_rd_en_o     = 1'b0;
        b_rd_en_o     = 1'b0;
        a_addr_o      = '0;
        b_addr_o      = '0;
        mac_clear_n_o = 1'b0;
        mac_enable_o  = 1'b0;
        c_wr_en_o     = 1'b0;
        c_addr_o      = '0;
        c_data_o      = '0;
        c_overflow_o  = 1'b0;
        ovf_sticky_o  = sticky_q;

        case (state_q)
            S_CLEAR: begin
                a_rd_en_o = 1'b1;
                b_rd_en_o = 1'b1;
                a_addr_o  = row_base + k_addr;
                b_addr_o  = k_addr * DIM_A + col;
            end
            S_ACCUM: begin
                mac_clear_n_o = 1'b1;
                mac_enable_o  = 1'b1;
                a_rd_en_o     = (k_q < K_DIM);
                b_rd_en_o     = (k_q < K_DIM);
                a_addr_o      = row_base + k_addr;
                b_addr_o      = k_addr * DIM_A + col;
            end
            S_WRITE: begin
                // Keep the MAC out of clear so its result stays stable.
                mac_clear_n_o = 1'b1;
                a_addr_o      = row_base + k_addr;
                b_addr_o      = k_addr * DIM_A + col;
                c_wr_en_o     = 1'b1;
                c_addr_o      = row_base + col;
                c_data_o      = mac_result_i;
                c_overflow_o  = mac_overflow_i;
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for matmul_mac_sequencer. Two instances (DIM=2 and DIM=4) share the
// clock and reset; each has its own behavioural A/B buffers and a two-stage
// MAC. A scoreboard of expected C writes is computed by plain matrix
// multiplication; a per-cycle checker compares the DUT outputs against it.
// -----------------------------------------------------------------------------
module tb_matmul_mac_sequencer;

    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          start    [2];
    logic          busy     [2];
    logic          done     [2];
    logic          a_rd_en  [2];
    logic          b_rd_en  [2];
    logic          clear_n  [2];
    logic          mac_en   [2];
    logic          mac_ovf  [2];
    logic          c_wr_en  [2];
    logic          c_ovf    [2];
    logic          sticky   [2];
    logic [AW-1:0] a_addr   [2];
    logic [AW-1:0] b_addr   [2];
    logic [AW-1:0] c_addr   [2];
    logic [DW-1:0] mac_res  [2];
    logic [DW-1:0] c_data   [2];

    logic [DW-1:0] amem [2][16];
    logic [DW-1:0] bmem [2][16];
    logic [DW-1:0] a_q  [2];
    logic [DW-1:0] b_q  [2];
    logic [31:0]   p1   [2];
    logic [31:0]   acc  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        matmul_mac_sequencer #(
            .DIM       ((g == 0) ? 2 : 4),
            .DATA_WIDTH(DW),
            .ADDR_WIDTH(AW)
        ) u_dut (
            .clock_i       (clk),
            .reset_ni      (rst_n),
            .start_i       (start[g]),
            .busy_o        (busy[g]),
            .done_o        (done[g]),
            .a_rd_en_o     (a_rd_en[g]),
            .a_addr_o      (a_addr[g]),
            .b_rd_en_o     (b_rd_en[g]),
            .b_addr_o      (b_addr[g]),
            .mac_clear_n_o (clear_n[g]),
            .mac_enable_o  (mac_en[g]),
            .mac_result_i  (mac_res[g]),
            .mac_overflow_i(mac_ovf[g]),
            .c_wr_en_o     (c_wr_en[g]),
            .c_addr_o      (c_addr[g]),
            .c_data_o      (c_data[g]),
            .c_overflow_o  (c_ovf[g]),
            .ovf_sticky_o  (sticky[g])
        );
    end

    // Registered-read buffers and a two-stage MAC (product, then accumulate).
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (a_rd_en[g]) a_q[g] <= amem[g][a_addr[g]];
            if (b_rd_en[g]) b_q[g] <= bmem[g][b_addr[g]];
            if (!clear_n[g]) begin
                p1[g]  <= '0;
                acc[g] <= '0;
            end else if (mac_en[g]) begin
                p1[g]  <= 32'(a_q[g]) * 32'(b_q[g]);
                acc[g] <= acc[g] + p1[g];
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            mac_res[g] = acc[g][DW-1:0];
            mac_ovf[g] = |acc[g][31:DW];
        end
    end

    int errors = 0;
    int checks = 0;

    // Scoreboard of expected writes and log of observed writes.
    int exp_addr [2][256];
    int exp_data [2][256];
    int exp_ovf  [2][256];
    int head     [2];
    int tail     [2];
    int log_addr [2][64];
    int log_data [2][64];
    int log_ovf  [2][64];
    int log_n    [2];

    // Per-cycle checker state.
    int cyc_no;
    int rd_cnt   [2];
    int clr_cnt  [2];
    int clr_last [2];
    int en_cnt   [2];
    int en_first [2];
    int en_last  [2];
    int wr_run   [2];
    int msticky  [2];
    int busy_prev[2];

    function automatic int dim_of(input int g);
        return (g == 0) ? 2 : 4;
    endfunction

    task automatic check(input string name, input int g, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s [dut%0d]: got %0d, expected %0d", name, g, got, exp);
        end
    endtask

    function automatic logic [31:0] outs(input int g);
        return {3'b0, busy[g], done[g], a_rd_en[g], b_rd_en[g], clear_n[g], mac_en[g],
                c_wr_en[g], c_ovf[g], sticky[g], a_addr[g], b_addr[g], c_addr[g], c_data[g]};
    endfunction

    // mode 0: A = 1.., B = 5..; 1: all 255; 2: mixed pattern; 3: small values
    task automatic set_mats(input int g, input int mode);
        for (int x = 0; x < 16; x++) begin
            case (mode)
                0:       begin amem[g][x] = DW'(x + 1);      bmem[g][x] = DW'(x + 5);           end
                1:       begin amem[g][x] = 8'd255;          bmem[g][x] = 8'd255;               end
                2:       begin amem[g][x] = DW'(x * 17 + 3); bmem[g][x] = DW'((x * 3) % 7 + 1); end
                default: begin amem[g][x] = DW'(x % 3);      bmem[g][x] = DW'(x % 2);           end
            endcase
        end
    endtask

    // Expected C = A x B by plain arithmetic, queued in write order.
    task automatic load_run(input int g);
        int d;
        int s;
        d = dim_of(g);
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                s = 0;
                for (int k = 0; k < d; k++) s += int'(amem[g][i*d+k]) * int'(bmem[g][k*d+j]);
                exp_addr[g][tail[g]] = i * d + j;
                exp_data[g][tail[g]] = s % 256;
                exp_ovf[g][tail[g]]  = (s > 255) ? 1 : 0;
                tail[g]++;
            end
        end
    endtask

    task automatic start_pulse(input int g);
        @(posedge clk);
        #1 start[g] = 1'b1;
        @(posedge clk);
        #1 start[g] = 1'b0;
    endtask

    // Called just after the accepting edge; the next negedge is cycle 1.
    task automatic wait_done(input int g, output int cyc, output int low);
        cyc = 1;
        low = 0;
        while (1) begin
            @(negedge clk);
            if (!busy[g]) low++;
            if (done[g]) break;
            cyc++;
            if (cyc > 2000) begin
                check("done timeout", g, 0, 1);
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int low;
        int nw;
        int lit[4];
        lit = '{19, 22, 43, 50};
        for (int g = 0; g < 2; g++) begin
            start[g] = 1'b0;
            head[g] = 0; tail[g] = 0; log_n[g] = 0;
            set_mats(g, 3);
        end
        cyc_no = 0;

        // Per-cycle compare process.
        fork
            forever begin
                @(negedge clk);
                cyc_no++;
                for (int g = 0; g < 2; g++) begin
                    int d;
                    int e;
                    d = dim_of(g);
                    if (!rst_n) begin
                        rd_cnt[g] = 0; clr_cnt[g] = 0; en_cnt[g] = 0; wr_run[g] = 0;
                        msticky[g] = 0; busy_prev[g] = 0;
                        continue;
                    end
                    if (busy[g] && !busy_prev[g]) begin
                        msticky[g] = 0; wr_run[g] = 0;
                        clr_cnt[g] = 0; en_cnt[g] = 0; rd_cnt[g] = 0;
                    end
                    check("ovf_sticky", g, sticky[g], msticky[g]);
                    if (busy[g] && !clear_n[g]) begin
                        clr_cnt[g]++;
                        clr_last[g] = cyc_no;
                    end
                    if (mac_en[g]) begin
                        if (en_cnt[g] == 0) en_first[g] = cyc_no;
                        en_cnt[g]++;
                        en_last[g] = cyc_no;
                    end
                    if (a_rd_en[g] || b_rd_en[g]) begin
                        if (head[g] == tail[g]) begin
                            check("read with no pending element", g, 1, 0);
                        end else begin
                            e = exp_addr[g][head[g]];
                            check("rd_en pair", g, {a_rd_en[g], b_rd_en[g]}, 3);
                            check("a_addr", g, a_addr[g], (e / d) * d + rd_cnt[g]);
                            check("b_addr", g, b_addr[g], rd_cnt[g] * d + (e % d));
                        end
                        rd_cnt[g]++;
                    end
                    if (c_wr_en[g]) begin
                        if (head[g] == tail[g]) begin
                            check("unexpected write", g, 1, 0);
                        end else begin
                            check("c_addr", g, c_addr[g], exp_addr[g][head[g]]);
                            check("c_data", g, c_data[g], exp_data[g][head[g]]);
                            check("c_overflow", g, c_ovf[g], exp_ovf[g][head[g]]);
                            msticky[g] = msticky[g] | exp_ovf[g][head[g]];
                            head[g]++;
                        end
                        check("clear cycles before element", g, clr_cnt[g], 1);
                        check("enable run length", g, en_cnt[g], d + 1);
                        check("enable contiguous", g, en_last[g] - en_first[g] + 1, en_cnt[g]);
                        check("clear right before enable", g, en_first[g], clr_last[g] + 1);
                        check("reads per element", g, rd_cnt[g], d);
                        if (log_n[g] < 64) begin
                            log_addr[g][log_n[g]] = int'(c_addr[g]);
                            log_data[g][log_n[g]] = int'(c_data[g]);
                            log_ovf[g][log_n[g]]  = int'(c_ovf[g]);
                            log_n[g]++;
                        end
                        wr_run[g]++;
                        clr_cnt[g] = 0; en_cnt[g] = 0; rd_cnt[g] = 0;
                    end else begin
                        check("c_data outside write", g, c_data[g], 0);
                        check("c_overflow outside write", g, c_ovf[g], 0);
                    end
                    if (done[g]) check("writes per run", g, wr_run[g], d * d);
                    busy_prev[g] = busy[g];
                end
            end
        join_none

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", 0, outs(0), 0);
        check("reset outputs", 1, outs(1), 0);
        #2 rst_n = 1'b1;

        // DIM=2 basic multiply.
        set_mats(0, 0);
        load_run(0);
        log_n[0] = 0;
        start_pulse(0);
        wait_done(0, cyc, low);
        check("done latency", 0, cyc, 21);
        check("write count", 0, log_n[0], 4);
        for (int n = 0; n < 4; n++) begin
            check("C literal addr", 0, log_addr[0][n], n);
            check("C literal data", 0, log_data[0][n], lit[n]);
        end
        check("sticky after run", 0, sticky[0], 0);

        // DIM=2 all 255: 2*65025 = 0x1FC02.
        set_mats(0, 1);
        load_run(0);
        log_n[0] = 0;
        start_pulse(0);
        wait_done(0, cyc, low);
        for (int n = 0; n < 4; n++) begin
            check("255 data", 0, log_data[0][n], 2);
            check("255 overflow", 0, log_ovf[0][n], 1);
        end
        check("sticky after overflow run", 0, sticky[0], 1);

        // DIM=4 protocol and ordering.
        set_mats(1, 2);
        load_run(1);
        log_n[1] = 0;
        start_pulse(1);
        wait_done(1, cyc, low);
        check("done latency", 1, cyc, 16 * 7 + 1);
        check("write count", 1, log_n[1], 16);
        for (int n = 0; n < 16; n++) check("c_addr order", 1, log_addr[1][n], n);

        // start held high for a whole run: no restart until IDLE.
        set_mats(0, 0);
        load_run(0);
        load_run(0);
        log_n[0] = 0;
        @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        wait_done(0, cyc, low);
        check("busy dropped mid-run", 0, low, 0);
        check("done latency with start held", 0, cyc, 21);
        check("writes with start held", 0, log_n[0], 4);
        @(negedge clk);
        check("idle after done", 0, busy[0], 0);
        @(negedge clk);
        check("restart accepted in idle", 0, busy[0], 1);
        start[0] = 1'b0;
        wait_done(0, cyc, low);
        check("writes over two runs", 0, log_n[0], 8);

        // Asynchronous reset during ACCUM of the second element.
        set_mats(0, 1);
        load_run(0);
        start_pulse(0);
        nw = 0;
        for (int t = 0; t < 100 && nw == 0; t++) begin
            @(negedge clk);
            if (c_wr_en[0]) nw++;
        end
        check("first write before reset", 0, nw, 1);
        @(negedge clk);
        @(negedge clk);
        check("in accum before reset", 0, mac_en[0], 1);
        check("sticky set before reset", 0, sticky[0], 1);
        #2 rst_n = 1'b0;
        #1 check("async reset outputs", 0, outs(0), 0);
        check("async reset outputs", 1, outs(1), 0);
        head[0] = tail[0];
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        set_mats(0, 0);
        load_run(0);
        log_n[0] = 0;
        start_pulse(0);
        wait_done(0, cyc, low);
        check("write count after reset", 0, log_n[0], 4);
        check("first addr after reset", 0, log_addr[0][0], 0);
        check("sticky after reset run", 0, sticky[0], 0);

        // Back-to-back runs on DIM=4: 4*65025 = 0x3F804.
        set_mats(1, 1);
        load_run(1);
        log_n[1] = 0;
        start_pulse(1);
        wait_done(1, cyc, low);
        check("sticky after first run", 1, sticky[1], 1);
        for (int n = 0; n < 16; n++) check("255 data dim4", 1, log_data[1][n], 4);
        set_mats(1, 3);
        load_run(1);
        @(posedge clk);
        #1 start[1] = 1'b1;
        @(negedge clk);
        check("idle before second run", 1, busy[1], 0);
        check("sticky held in idle", 1, sticky[1], 1);
        @(posedge clk);
        #1 start[1] = 1'b0;
        wait_done(1, cyc, low);
        check("second run latency", 1, cyc, 16 * 7 + 1);
        check("sticky after second run", 1, sticky[1], 0);
        check("second run writes", 1, log_n[1], 32);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/matmul_mac_sequencer.md
Name: matmul_mac_sequencer

Overview:
Controller that computes C = A x B for square DIM x DIM matrices using one shared mac_unit. It reads A and B operands from two registered-read buffers and sequences the MAC's clear and enable. Each finished dot product is written to a C buffer. It sits between the top-level command interface (start/done) and the MAC datapath.

Parameters:
DIM, 4, matrix dimension (rows = cols); valid range 2..15
DATA_WIDTH, 8, operand/result width; must match the attached mac_unit
ADDR_WIDTH, 4, buffer address width; must satisfy 2**ADDR_WIDTH >= DIM*DIM

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
start  in  1  begin a full matrix multiply; sampled in IDLE only
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last C element is written
a_rd_en  out  1  A buffer read strobe
a_addr  out  ADDR_WIDTH  A address, row-major: i*DIM+k
b_rd_en  out  1  B buffer read strobe
b_addr  out  ADDR_WIDTH  B address, row-major: k*DIM+j
mac_clear_n  out  1  drives the MAC's synchronous active-low reset
mac_enable  out  1  drives the MAC enable
mac_result  in  DATA_WIDTH  MAC truncated accumulator
mac_overflow  in  1  MAC overflow flag
c_wr_en  out  1  C buffer write strobe
c_addr  out  ADDR_WIDTH  C address: i*DIM+j
c_data  out  DATA_WIDTH  value written to C
c_overflow  out  1  mac_overflow for the element being written
ovf_sticky  out  1  OR of c_overflow over the current/last run

Behaviour:
- Reset (async, any time, including mid-run): state IDLE; i/j/k counters 0; busy, done, a_rd_en, b_rd_en, mac_enable, c_wr_en, c_overflow, ovf_sticky = 0; mac_clear_n = 0; all addresses = 0; c_data = 0.
- States: IDLE, CLEAR, ACCUM, WRITE, DONE. Outputs are decoded from registered state and counters only.
- IDLE: mac_clear_n = 0, which holds the MAC cleared. start = 1 -> CLEAR with i = j = 0, and ovf_sticky cleared. start is ignored in every other state.
- CLEAR (1 cycle): mac_clear_n = 0; k = 0; a_rd_en = b_rd_en = 1 with addresses for k = 0. Next state is ACCUM.
- ACCUM (exactly DIM+1 cycles, numbered 1..DIM+1): mac_clear_n = 1; mac_enable = 1 throughout.
  - In cycles 1..DIM-1, the read strobes are high with the addresses for k = cycle number.
  - In cycles DIM and DIM+1, the read strobes are 0 and the addresses hold their last value.
  - Buffer data appears one cycle after its address. The MAC's 2-stage pipeline then holds the full sum after the last ACCUM edge.
  - The extra product captured into MAC stage 1 on the final edge is discarded by the next CLEAR.
- WRITE (1 cycle): c_wr_en = 1; c_addr = i*DIM+j; c_data = mac_result; c_overflow = mac_overflow (passthrough). ovf_sticky |= mac_overflow on the closing edge.
  - j < DIM-1: j++ and go to CLEAR.
  - j = DIM-1 and i < DIM-1: j = 0, i++, go to CLEAR.
  - Otherwise go to DONE.
- DONE (1 cycle): done = 1, busy = 1; next state IDLE. A start high in DONE is ignored; a new start is accepted in IDLE on the following cycle.
- Timing per element: DIM+3 cycles. The run is DIM*DIM*(DIM+3) cycles from the first CLEAR to the end of the last WRITE, then 1 DONE cycle.
- Widths: address arithmetic is done at ADDR_WIDTH with no wrap for legal DIM. c_data is the MAC's truncated low DATA_WIDTH bits; the controller does no saturation.
- Outside ACCUM, mac_enable = 0; outside WRITE, c_wr_en = 0 and c_data/c_overflow = 0.
- ovf_sticky holds its value after DONE until the next accepted start or a reset.

Test Plan:
- DIM=2, DATA_WIDTH=8, A=[1,2,3,4], B=[5,6,7,8], pulse start:
  - required C writes, in order: addr0 = 19, addr1 = 22, addr2 = 43, addr3 = 50;
  - done pulses exactly 21 cycles after the start edge (20 run cycles plus DONE);
  - ovf_sticky = 0.
- DIM=2, A and B all 255: every c_data = 0x02 with c_overflow = 1; ovf_sticky = 1 after done.
- Protocol check, DIM=4: per element, mac_enable is high for exactly 5 consecutive cycles, preceded by one mac_clear_n = 0 cycle. Exactly 4 rd_en cycles precede each c_wr_en. c_addr runs 0..15 in order.
- start held high throughout a run: no restart, busy stays 1, exactly DIM*DIM writes occur. The second start is accepted only in IDLE after done.
- Assert reset asynchronously during ACCUM of element 2:
  - all outputs go to reset values immediately, with no clock edge;
  - after release, a fresh start produces the correct full C, starting at addr0;
  - ovf_sticky = 0.
- Back-to-back runs: start asserted in the IDLE cycle right after done.
  - The second run's results are correct; ovf_sticky from the first run is cleared on acceptance.
